uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial receiver for the 8N1 UART line. It is the receiving end of the link whose transmit side is paced by the clock divider.
- Detects the start bit and times each bit with an internal baud counter.
- Samples every bit at mid-bit, checks the stop bit.
- Presents each received byte on a valid/ready output register to the CPU-side consumer.

Parameters:
CLKS_PER_BIT, 868, clk_in cycles per serial bit (100 MHz / 115200); legal values are 4 and above.
SYNC_STAGES, 2, flip-flops in the rx_in synchroniser; legal values are 2 and above.

Ports:
clk_in  input  1  system clock; all logic on its rising edge
rst  input  1  asynchronous active-low reset
rx_in  input  1  asynchronous serial line; idle level is 1
data_out  output  8  received byte, LSB received first
valid_out  output  1  data_out holds an unconsumed byte
ready_in  input  1  consumer accepts data_out when valid_out && ready_in
frame_err  output  1  one-cycle pulse: stop bit sampled as 0
overrun  output  1  one-cycle pulse: byte completed while previous byte still unconsumed

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, bit and baud counters=0, synchroniser stages=1.
  - data_out=8'h00, valid_out=0, frame_err=0, overrun=0.
  - Reset asserted mid-frame aborts the frame; no partial byte is ever presented.
- Synchroniser:
  - rx_in passes through SYNC_STAGES flops; all logic uses the synchronised value rxs.
  - Baud counter width is $clog2(CLKS_PER_BIT).
  - HALF = CLKS_PER_BIT/2, integer division.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: when rxs=0, go to START and clear the baud counter.
- START:
  - Count to HALF-1, then sample rxs.
  - rxs=0: go to DATA, clear the bit index and baud counter.
  - rxs=1: glitch; return to IDLE with no pulse.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rxs into a shift register, LSB first.
  - After bit index 7, go to STOP. The bit index wraps 7 to 0 only through a state change.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rxs.
  - rxs=1: byte complete; go to IDLE.
  - rxs=0: frame_err=1 for one cycle, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rxs=1, then go to IDLE. A break condition produces exactly one frame_err.
- Byte completion:
  - valid_out=0, or valid_out=1 && ready_in=1 in the same cycle: load data_out, valid_out=1 on the next edge.
  - valid_out=1 && ready_in=0: overrun=1 for one cycle, drop the new byte, keep the old data_out and valid_out.
- Handshake:
  - valid_out falls on the edge after valid_out && ready_in, unless a simultaneous load re-asserts it.
  - data_out is stable while valid_out=1.
  - ready_in is ignored while valid_out=0.
- Latency:
  - Stop sample occurs HALF + 9*CLKS_PER_BIT cycles after the cycle in which rxs first reads 0.
  - valid_out rises 1 cycle after that sample.
- Receiver keeps running regardless of valid_out; back-to-back frames need no idle gap beyond the stop bit.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: an even-parity bit is sampled in state PARITY between DATA and STOP, using the same timing.
  - Extra output port parity_err (1 bit): one-cycle pulse when XOR of the 8 data bits and the parity bit is 1.
  - On parity error the byte is discarded and the FSM continues to STOP normally.
  - If both errors occur, both pulses fire, in their respective sample cycles.
  - Latency becomes HALF + 10*CLKS_PER_BIT + 1.
- Undefined: 8N1 only; no PARITY state and no parity_err port.

Test Plan:
All scenarios use CLKS_PER_BIT=16.
1. Reset then idle line held at 1 for 1000 cycles -> valid_out, frame_err and overrun stay 0; data_out=8'h00.
2. Send 8'hA5 8N1, ready_in=1 -> valid_out pulses 1 cycle with data_out=8'hA5, exactly 8+144+1 cycles after rxs falls; no error pulses.
3. Send 8'h3C then 8'hC3 back-to-back with ready_in=0 -> first byte: data_out=8'h3C, valid_out=1. Second byte: overrun pulses once, data_out stays 8'h3C. Raise ready_in -> valid_out=0 next cycle.
4. Send 8'h55 with stop bit forced 0, then hold the line low 50 cycles -> single frame_err pulse, valid_out stays 0. Line returns high, then send 8'h0F -> data_out=8'h0F received.
5. Drive rx_in low for 5 cycles (a glitch) -> FSM returns to IDLE, no outputs. Then assert rst mid-way through byte 8'hFF -> all outputs 0 and state=IDLE. Release rst and send 8'h81 -> received correctly.
6. UART_RX_PARITY_EN defined: send 8'h07 with parity bit 1 -> data_out=8'h07 presented. Send 8'h07 with parity bit 0 -> parity_err pulses once, valid_out stays 0.

Source files
------------

// File: rtl/uart_rx_if.sv
// CPU-side byte handshake of the UART receiver: valid/ready data register plus error pulses.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
   logic [7:0] data_out;
   logic       valid_out;
   logic       ready_in;
   logic       frame_err;
   logic       overrun;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   modport master (
      output data_out,
      output valid_out,
      output frame_err,
      output overrun,
`ifdef UART_RX_PARITY_EN
      output parity_err,
`endif
      input  ready_in
   );

   modport slave (
      input  data_out,
      input  valid_out,
      input  frame_err,
      input  overrun,
`ifdef UART_RX_PARITY_EN
      input  parity_err,
`endif
      output ready_in
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ready output register.
// Define UART_RX_PARITY_EN for 8E1 framing with an extra parity_err pulse.
module uart_rx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int SYNC_STAGES  = 2
) (
   input  logic     clk_in,
   input  logic     rst,
   input  logic     rx_in,
   uart_rx_if.master bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_IDLE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;
   logic            ovr_q, ovr_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic            rxs;
   logic            stop_done;
   logic            byte_ok;
   logic            load;
`ifdef UART_RX_PARITY_EN
   logic            par_bad_q, par_bad_d;
   logic            perr_q, perr_d;
`endif

   // Idle-high reset value keeps a reset release from looking like a start bit.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) sync_q <= '1;
      else      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
   end
   assign rxs = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= par_bad_d;
         perr_q    <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
`endif
      unique case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!rxs) state_d = START;
         end
         START: if (baud_q == HALF_M1) begin
            baud_d  = '0;
            bit_d   = '0;
            state_d = rxs ? IDLE : DATA;
         end
         DATA: if (baud_q == FULL_M1) begin
            baud_d  = '0;
            shift_d = {rxs, shift_q[7:1]};
            if (bit_q == 3'd7) begin
               bit_d = '0;
`ifdef UART_RX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end else begin
               bit_d = bit_q + 3'd1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (baud_q == FULL_M1) begin
            baud_d    = '0;
            par_bad_d = ^shift_q ^ rxs;
            state_d   = STOP;
         end
`endif
         STOP: if (baud_q == FULL_M1) begin
            baud_d  = '0;
            state_d = rxs ? IDLE : WAIT_IDLE;
         end
         WAIT_IDLE: begin
            baud_d = '0;
            if (rxs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A completed byte either replaces a consumed one or is dropped as an overrun.
   always_comb begin
      stop_done = (state_q == STOP) && (baud_q == FULL_M1);
`ifdef UART_RX_PARITY_EN
      byte_ok = stop_done && rxs && !par_bad_q;
      perr_d  = (state_q == PARITY) && (baud_q == FULL_M1) && (^shift_q ^ rxs);
`else
      byte_ok = stop_done && rxs;
`endif
      ferr_d  = stop_done && !rxs;
      load    = byte_ok && (!valid_q || bus.ready_in);
      ovr_d   = byte_ok && valid_q && !bus.ready_in;
      valid_d = load || (valid_q && !bus.ready_in);
      data_d  = load ? shift_q : data_q;
   end

   assign bus.data_out  = data_q;
   assign bus.valid_out = valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: vector table plus hand-written corner sequences.
module tb_uart_rx;
   localparam int CPB  = 16;
   localparam int SYNC = 2;
   localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = SYNC + HALF + 10 * CPB + 1;
`else
   localparam int LAT = SYNC + HALF + 9 * CPB + 1;
`endif

   logic clk_in = 1'b0;
   logic rst    = 1'b0;
   logic rx_in  = 1'b1;

   uart_rx_if bus ();

   uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
      .clk_in (clk_in),
      .rst    (rst),
      .rx_in  (rx_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int n_bytes = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, rise_cyc = 0;
   logic [7:0] last_data = 8'h00;
   logic prev_valid = 1'b0;
   always @(negedge clk_in) begin
      if (bus.valid_out && bus.ready_in) begin
         n_bytes   <= n_bytes + 1;
         last_data <= bus.data_out;
      end
      if (bus.valid_out && !prev_valid) rise_cyc <= cyc;
      if (bus.frame_err) n_ferr <= n_ferr + 1;
      if (bus.overrun)   n_ovr  <= n_ovr + 1;
`ifdef UART_RX_PARITY_EN
      if (bus.parity_err) n_perr <= n_perr + 1;
`endif
      prev_valid <= bus.valid_out;
   end

   int n_vec = 0, n_err = 0, t_start = 0;
   int b0, f0, o0, p0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Call just after a posedge; returns on the posedge ending the stop bit.
   task automatic send(input logic [7:0] d, input logic par, input logic stop);
      #1 rx_in = 1'b0;
      t_start = cyc;
      repeat (CPB) @(posedge clk_in);
      for (int i = 0; i < 8; i++) begin
         #1 rx_in = d[i];
         repeat (CPB) @(posedge clk_in);
      end
`ifdef UART_RX_PARITY_EN
      #1 rx_in = par;
      repeat (CPB) @(posedge clk_in);
`endif
      #1 rx_in = stop;
      repeat (CPB) @(posedge clk_in);
   endtask

   task automatic snap();
      b0 = n_bytes; f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
   endtask

   typedef struct {
      logic [7:0] d;
      logic       par;
      logic       stop;
      int         exp_bytes;
      int         exp_ferr;
      int         exp_perr;
   } vec_t;

   vec_t vecs[8];
   int   nv;

   initial begin
      nv = 0;
      vecs[nv++] = '{8'hA5, 1'b0, 1'b1, 1, 0, 0};
      vecs[nv++] = '{8'h00, 1'b0, 1'b1, 1, 0, 0};
      vecs[nv++] = '{8'hFF, 1'b0, 1'b1, 1, 0, 0};
      vecs[nv++] = '{8'h01, 1'b1, 1'b1, 1, 0, 0};
      vecs[nv++] = '{8'h55, 1'b0, 1'b0, 0, 1, 0};
      vecs[nv++] = '{8'h80, 1'b1, 1'b1, 1, 0, 0};
`ifdef UART_RX_PARITY_EN
      vecs[nv++] = '{8'h07, 1'b1, 1'b1, 1, 0, 0};
      vecs[nv++] = '{8'h07, 1'b0, 1'b1, 0, 0, 1};
`endif
      bus.ready_in = 1'b1;

      // Reset state and a long idle line.
      repeat (4) @(posedge clk_in);
      @(negedge clk_in);
      chk("reset valid", int'(bus.valid_out), 0);
      chk("reset data", int'(bus.data_out), 0);
      #1 rst = 1'b1;
      repeat (1000) @(posedge clk_in);
      @(negedge clk_in);
      chk("idle bytes", n_bytes, 0);
      chk("idle ferr", n_ferr, 0);
      chk("idle ovr", n_ovr, 0);
      chk("idle data", int'(bus.data_out), 0);

      for (int v = 0; v < nv; v++) begin
         snap();
         @(posedge clk_in);
         send(vecs[v].d, vecs[v].par, vecs[v].stop);
         #1 rx_in = 1'b1;
         repeat (2 * CPB) @(posedge clk_in);
         @(negedge clk_in);
         chk($sformatf("v%0d bytes", v), n_bytes - b0, vecs[v].exp_bytes);
         chk($sformatf("v%0d ferr", v), n_ferr - f0, vecs[v].exp_ferr);
         chk($sformatf("v%0d ovr", v), n_ovr - o0, 0);
`ifdef UART_RX_PARITY_EN
         chk($sformatf("v%0d perr", v), n_perr - p0, vecs[v].exp_perr);
`endif
         if (vecs[v].exp_bytes != 0) begin
            chk($sformatf("v%0d data", v), int'(last_data), int'(vecs[v].d));
            chk($sformatf("v%0d latency", v), rise_cyc - t_start, LAT);
         end
      end

      // Back-to-back frames with the consumer stalled.
      bus.ready_in = 1'b0;
      snap();
      @(posedge clk_in);
      send(8'h3C, 1'b0, 1'b1);
      send(8'hC3, 1'b0, 1'b1);
      #1 rx_in = 1'b1;
      repeat (20) @(posedge clk_in);
      @(negedge clk_in);
      chk("b2b valid", int'(bus.valid_out), 1);
      chk("b2b data", int'(bus.data_out), 'h3C);
      chk("b2b ovr", n_ovr - o0, 1);
      @(posedge clk_in);
      #1 bus.ready_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      chk("b2b drain valid", int'(bus.valid_out), 0);
      chk("b2b drain bytes", n_bytes - b0, 1);
      chk("b2b drain data", int'(last_data), 'h3C);

      // Break: stop bit low, line held low, then recovery.
      snap();
      @(posedge clk_in);
      send(8'h55, 1'b0, 1'b0);
      repeat (50) @(posedge clk_in);
      #1 rx_in = 1'b1;
      repeat (40) @(posedge clk_in);
      @(negedge clk_in);
      chk("break ferr", n_ferr - f0, 1);
      chk("break bytes", n_bytes - b0, 0);
      chk("break valid", int'(bus.valid_out), 0);
      @(posedge clk_in);
      send(8'h0F, 1'b0, 1'b1);
      #1 rx_in = 1'b1;
      repeat (2 * CPB) @(posedge clk_in);
      @(negedge clk_in);
      chk("recover bytes", n_bytes - b0, 1);
      chk("recover data", int'(last_data), 'h0F);

      // Short start glitch.
      snap();
      @(posedge clk_in);
      #1 rx_in = 1'b0;
      repeat (5) @(posedge clk_in);
      #1 rx_in = 1'b1;
      repeat (12 * CPB) @(posedge clk_in);
      @(negedge clk_in);
      chk("glitch bytes", n_bytes - b0, 0);
      chk("glitch ferr", n_ferr - f0, 0);

      // Asynchronous reset in the middle of a 8'hFF frame.
      snap();
      @(posedge clk_in);
      #1 rx_in = 1'b0;
      repeat (CPB) @(posedge clk_in);
      #1 rx_in = 1'b1;
      repeat (3 * CPB) @(posedge clk_in);
      #1 rst = 1'b0;
      #1;
      chk("rst data", int'(bus.data_out), 0);
      chk("rst valid", int'(bus.valid_out), 0);
      chk("rst ferr", int'(bus.frame_err), 0);
      chk("rst ovr", int'(bus.overrun), 0);
      repeat (3) @(posedge clk_in);
      #1 rst = 1'b1;
      repeat (20 * CPB) @(posedge clk_in);
      @(negedge clk_in);
      chk("rst no partial", n_bytes - b0, 0);
      chk("rst no ferr", n_ferr - f0, 0);
      @(posedge clk_in);
      send(8'h81, 1'b0, 1'b1);
      #1 rx_in = 1'b1;
      repeat (2 * CPB) @(posedge clk_in);
      @(negedge clk_in);
      chk("post-rst bytes", n_bytes - b0, 1);
      chk("post-rst data", int'(last_data), 'h81);
      chk("post-rst latency", rise_cyc - t_start, LAT);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
